// File: rtl/ddr3_arbiter.sv
// Arbitrates the renderer write port and the display read port onto the MIG app interface.
// Reads win by default; a write that has waited out STARVE_LIMIT read grants wins the next one.
module ddr3_arbiter #(
    parameter int ADDR_WIDTH      = 28,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int STARVE_LIMIT    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               calib_done,
    input  logic                               wr_req,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               wr_ack,
    input  logic                               rd_req,
    input  logic [ADDR_WIDTH-1:0]              rd_addr,
    output logic                               rd_ack,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_data_valid,
    output logic                               app_en,
    output logic [2:0]                         app_cmd,
    output logic [ADDR_WIDTH-1:0]              app_addr,
    input  logic                               app_rdy,
    output logic [DATA_WIDTH-1:0]              app_wdf_data,
    output logic                               app_wdf_wren,
    output logic                               app_wdf_end,
    input  logic                               app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]              app_rd_data,
    input  logic                               app_rd_data_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [OW-1:0] MAX_CNT    = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    cmd_done_q, cmd_done_d;
    logic                    data_done_q, data_done_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic [OW-1:0]           out_q, out_d;

    logic cmd_fire;
    logic data_fire;
    logic rd_ok;
    logic starve_hit;

    always_comb begin
        cmd_fire   = (state_q == WR) && !cmd_done_q && app_rdy;
        data_fire  = (state_q == WR) && !data_done_q && app_wdf_rdy;
        rd_ack     = (state_q == RD) && app_rdy;
        // Either handshake may land first or both in the same cycle.
        wr_ack     = (state_q == WR) && (cmd_done_q || cmd_fire)
                     && (data_done_q || data_fire);
        rd_ok      = rd_req && (out_q < MAX_CNT);
        starve_hit = starve_q >= STARVE_MAX;
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        unique case (state_q)
            IDLE: begin
                if (calib_done) begin
                    if (rd_ok && !(wr_req && starve_hit)) begin
                        state_d = RD;
                        cmd_d   = CMD_RD;
                        addr_d  = rd_addr;
                    end else if (wr_req) begin
                        state_d = WR;
                        cmd_d   = CMD_WR;
                        addr_d  = wr_addr;
                        wdata_d = wr_data;
                    end
                end
            end
            RD: begin
                if (rd_ack) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (wr_ack) begin
                    state_d     = IDLE;
                    cmd_done_d  = 1'b0;
                    data_done_d = 1'b0;
                end else begin
                    cmd_done_d  = cmd_done_q | cmd_fire;
                    data_done_d = data_done_q | data_fire;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (wr_ack) begin
            starve_d = '0;
        end else if (rd_ack && wr_req && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
        // A return with nothing in flight is stale and ignored.
        out_d = out_q;
        if (rd_ack && !app_rd_data_valid) begin
            out_d = out_q + 1'b1;
        end else if (!rd_ack && app_rd_data_valid && out_q != '0) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            starve_q    <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
            starve_q    <= starve_d;
            out_q       <= out_d;
        end
    end

    assign app_en         = (state_q == RD) || ((state_q == WR) && !cmd_done_q);
    assign app_wdf_wren   = (state_q == WR) && !data_done_q;
    assign app_wdf_end    = app_wdf_wren;
    assign app_cmd        = cmd_q;
    assign app_addr       = addr_q;
    assign app_wdf_data   = wdata_q;
    assign rd_data        = app_rd_data;
    assign rd_data_valid  = app_rd_data_valid;
    assign rd_outstanding = out_q;

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Bench for ddr3_arbiter: directed scenarios, then random clients and MIG
// checked against a transaction-level arbitration model.
module tb_ddr3_arbiter;

    localparam int AW  = 28;
    localparam int DW  = 64;
    localparam int MAX = 8;
    localparam int LIM = 2;
    localparam int OW  = $clog2(MAX) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          calib_done;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic [OW-1:0] rd_outstanding;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ddr3_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MAX),
        .STARVE_LIMIT   (LIM)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .calib_done       (calib_done),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ack           (wr_ack),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .app_en           (app_en),
        .app_cmd          (app_cmd),
        .app_addr         (app_addr),
        .app_rdy          (app_rdy),
        .app_wdf_data     (app_wdf_data),
        .app_wdf_wren     (app_wdf_wren),
        .app_wdf_end      (app_wdf_end),
        .app_wdf_rdy      (app_wdf_rdy),
        .app_rd_data      (app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .rd_outstanding   (rd_outstanding)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule seen from outside: 0 none, 1 read, 2 write.
    function automatic int decide(int m_out, int m_starve);
        if (!calib_done) return 0;
        if (rd_req && m_out < MAX && !(wr_req && m_starve >= LIM)) return 1;
        if (wr_req) return 2;
        return 0;
    endfunction

    int got_k[$];
    int exp_k[6] = '{1, 1, 2, 1, 1, 2};
    int n;
    logic bad;

    // random-phase model state
    int   m_out, m_starve, phase, kind, pend, kobs, c_low;
    logic wc, wd, cn, dn, e_rd, e_wr, e_en, e_wren;
    logic rd_acked, wr_acked;

    initial begin
        rst = 1'b1; calib_done = 1'b1;
        wr_req = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = '0; app_rd_data_valid = 1'b0;
        next(); next();
        @(negedge clk);
        check("reset", {app_en, app_wdf_wren, app_wdf_end, wr_ack, rd_ack,
                        rd_outstanding, app_cmd, app_addr, app_wdf_data}, '0);
        next(); rst = 1'b0;
        @(negedge clk); next();

        // single write, everything ready
        wr_req = 1; wr_addr = 'h40; wr_data = 'hA5A5;
        @(negedge clk);
        check("t1_idle", {app_en, app_wdf_wren, wr_ack}, 3'b000);
        next();
        @(negedge clk);
        check("t1_cmd", {app_en, app_cmd, app_wdf_wren, app_wdf_end, wr_ack, app_addr},
              {1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 28'h40});
        check("t1_data", app_wdf_data, 64'hA5A5);
        next(); wr_req = 0;
        @(negedge clk);
        check("t1_done", {app_en, app_wdf_wren, wr_ack}, 3'b000);
        next();

        // split write handshake
        wr_req = 1; wr_addr = 'h80; wr_data = 'h1234; app_wdf_rdy = 0;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            next(); app_wdf_rdy = (i == 4);
            @(negedge clk);
            check("split_en", app_en, (i == 1));
            check("split_wren", {app_wdf_wren, app_wdf_end}, 2'b11);
            check("split_ack", wr_ack, (i == 4));
        end
        next(); wr_req = 0; app_wdf_rdy = 1;
        @(negedge clk); next();

        // both clients: two reads then one write, twice
        rd_req = 1; wr_req = 1; rd_addr = 'h100; wr_addr = 'h200; wr_data = 'h77;
        for (int c = 0; c < 60 && got_k.size() < 6; c++) begin
            @(negedge clk);
            if (rd_ack) got_k.push_back(1);
            if (wr_ack) got_k.push_back(2);
            next();
        end
        rd_req = 0; wr_req = 0;
        check("grant_n", got_k.size(), 6);
        for (int i = 0; i < got_k.size() && i < 6; i++)
            check($sformatf("grant_%0d", i), got_k[i], exp_k[i]);
        for (int i = 0; i < 4; i++) begin
            app_rd_data_valid = 1; @(negedge clk); next();
        end
        app_rd_data_valid = 0;
        @(negedge clk);
        check("drain0", rd_outstanding, 0);
        next();

        // outstanding limit
        rd_req = 1; rd_addr = 'h300; n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); n += int'(rd_ack); next();
        end
        @(negedge clk);
        check("lim_acks", n, 8);
        check("lim_hold", {app_en, rd_outstanding}, {1'b0, 4'd8});
        next(); app_rd_data_valid = 1;
        @(negedge clk); next();
        app_rd_data_valid = 0; n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); n += int'(rd_ack); next();
        end
        rd_req = 0;
        check("lim_one_more", n, 1);
        @(negedge clk);
        check("lim_full", rd_outstanding, 8);
        next();

        // same-cycle accept and return at 3
        for (int i = 0; i < 5; i++) begin
            app_rd_data_valid = 1; @(negedge clk); next();
        end
        app_rd_data_valid = 0;
        @(negedge clk);
        check("at3", rd_outstanding, 3);
        next(); rd_req = 1; rd_addr = 'h400;
        @(negedge clk); next();
        app_rd_data_valid = 1;
        @(negedge clk);
        check("same_ack", rd_ack, 1);
        next(); app_rd_data_valid = 0; rd_req = 0;
        @(negedge clk);
        check("same_cnt", rd_outstanding, 3);
        next();
        for (int i = 0; i < 3; i++) begin
            app_rd_data_valid = 1; @(negedge clk); next();
        end
        app_rd_data_valid = 0;

        // calibration gating
        calib_done = 0; rd_req = 1; wr_req = 1; bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); bad |= app_en | app_wdf_wren; next();
        end
        check("calib_gate", bad, 0);
        rd_req = 0; wr_req = 0; calib_done = 1;
        @(negedge clk); next();

        // reset in the middle of a write
        rd_req = 1; rd_addr = 'h500;
        @(negedge clk); next();
        @(negedge clk);
        check("t7_rd", rd_ack, 1);
        next(); rd_req = 0; wr_req = 1; wr_addr = 'h600; wr_data = 'hBEEF;
        app_rdy = 0; app_wdf_rdy = 0;
        @(negedge clk); next();
        @(negedge clk);
        check("t7_wr", {app_en, app_wdf_wren, rd_outstanding}, {2'b11, 4'd1});
        next(); rst = 1;
        @(negedge clk);
        check("t7_rst", {app_en, app_wdf_wren, app_wdf_end, wr_ack, rd_ack,
                         rd_outstanding, app_cmd, app_addr, app_wdf_data}, '0);
        next(); app_rdy = 1; app_wdf_rdy = 1; bad = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); bad |= wr_ack; next();
        end
        rst = 0; wr_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); bad |= wr_ack | app_en; next();
        end
        check("t7_noack", bad, 0);

        // random clients and MIG
        m_out = 0; m_starve = 0; phase = 0; pend = 0; kind = 0; c_low = 0;
        wc = 0; wd = 0; rd_acked = 0; wr_acked = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c_low > 0) c_low--;
            else if ($urandom_range(0, 99) == 0) c_low = $urandom_range(1, 6);
            calib_done = (c_low == 0);
            if (!rd_req || rd_acked) begin
                rd_req  = ($urandom_range(0, 2) != 0);
                rd_addr = AW'($urandom);
            end
            if (!wr_req || wr_acked) begin
                wr_req  = ($urandom_range(0, 2) != 0);
                wr_addr = AW'($urandom);
                wr_data = {$urandom, $urandom};
            end
            app_rdy     = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 4) > 1);
            if (m_out > 0)
                app_rd_data_valid = (c < 2000) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 11) == 0);
            else
                app_rd_data_valid = ($urandom_range(0, 19) == 0);
            app_rd_data = {$urandom, $urandom};

            @(negedge clk);
            check("pass", {rd_data_valid, rd_data}, {app_rd_data_valid, app_rd_data});
            check("outst", rd_outstanding, m_out);
            kobs = (app_en && app_cmd == 3'b001) ? 1 : (app_en || app_wdf_wren) ? 2 : 0;
            if (phase == 0) begin
                check("grant", kobs, pend);
                if (pend != 0) begin
                    phase = 1; kind = pend; wc = 0; wd = 0;
                end
            end
            e_rd = 0; e_wr = 0;
            if (phase == 1) begin
                if (kind == 1) begin
                    check("rd_cmd", {app_en, app_cmd, app_wdf_wren, app_addr},
                          {1'b1, 3'b001, 1'b0, rd_addr});
                    e_rd = app_rdy;
                end else begin
                    e_en = !wc; e_wren = !wd;
                    check("wr_hs", {app_en, app_wdf_wren, app_wdf_end},
                          {e_en, e_wren, e_wren});
                    if (e_en) check("wr_addr", {app_cmd, app_addr}, {3'b000, wr_addr});
                    if (e_wren) check("wr_data", app_wdf_data, wr_data);
                    cn = !wc && app_rdy;
                    dn = !wd && app_wdf_rdy;
                    e_wr = (wc || cn) && (wd || dn);
                    wc |= cn; wd |= dn;
                end
            end
            check("acks", {rd_ack, wr_ack}, {e_rd, e_wr});
            if (e_rd || e_wr) begin
                phase = 0; pend = 0;
            end else if (phase == 0) begin
                pend = decide(m_out, m_starve);
            end
            if (e_wr) m_starve = 0;
            else if (e_rd && wr_req && m_starve < LIM) m_starve++;
            if (e_rd && !app_rd_data_valid) m_out++;
            else if (!e_rd && app_rd_data_valid && m_out > 0) m_out--;
            rd_acked = e_rd; wr_acked = e_wr;
            next();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr3_arbiter.md
Name: ddr3_arbiter

Overview:
Shares the single MIG DDR3 user (app) interface between the renderer's write client and the display's read client, so neither owns the bus outright. Performs request arbitration, the MIG command/write-data handshakes, outstanding-read accounting and write-starvation protection. It sits in the ui_clk domain, with the renderer on the write port, the VGA framebuffer on the read port and the MIG app_* signals on the memory side.

Parameters:
ADDR_WIDTH, 28, width of the MIG app_addr and of the client addresses
DATA_WIDTH, 64, width of the MIG app data bus
MAX_OUTSTANDING, 8, maximum accepted reads still awaiting data (power of two, at least 2)
STARVE_LIMIT, 16, number of consecutive read grants after which a pending write wins one grant

Ports:
clk  in  1  MIG ui_clk
rst  in  1  asynchronous, active-high reset
calib_done  in  1  MIG init_calib_complete; no grants are issued while it is low
wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_ack  out  1  one-cycle pulse: command and data both accepted by MIG
rd_req  in  1  read request; held with rd_addr until rd_ack
rd_addr  in  ADDR_WIDTH  read address
rd_ack  out  1  one-cycle pulse: read command accepted
rd_data  out  DATA_WIDTH  app_rd_data, passed through
rd_data_valid  out  1  app_rd_data_valid, passed through
app_en  out  1  MIG command valid
app_cmd  out  3  000 = write, 001 = read
app_addr  out  ADDR_WIDTH  MIG command address
app_rdy  in  1  MIG command ready
app_wdf_data  out  DATA_WIDTH  MIG write data
app_wdf_wren  out  1  MIG write-data valid
app_wdf_end  out  1  equals app_wdf_wren (one beat per burst)
app_wdf_rdy  in  1  MIG write-data ready
app_rd_data  in  DATA_WIDTH  MIG read data
app_rd_data_valid  in  1  MIG read-data valid
rd_outstanding  out  log2(MAX_OUTSTANDING)+1  number of reads in flight

Behaviour:
- Reset values:
  - State is IDLE.
  - app_en, app_wdf_wren, app_wdf_end, wr_ack and rd_ack are 0.
  - app_cmd, app_addr and app_wdf_data are 0.
  - rd_outstanding, the starvation counter and both write-done flags are 0.
- FSM states:
  - IDLE: evaluate requests and pick a grant.
  - RD: issue one read command.
  - WR: issue one write command plus its data beat.
- IDLE grant rules, evaluated only when calib_done is 1:
  - Read eligibility: rd_req is 1 and rd_outstanding < MAX_OUTSTANDING.
  - Reads have priority: an eligible read goes to RD, unless wr_req is 1 and starve_cnt >= STARVE_LIMIT, in which case the write goes to WR.
  - Otherwise, wr_req = 1 goes to WR.
- Grant latency: the address, data and command are registered on the IDLE-to-grant transition. The earliest app_en is the cycle after the request is first seen in IDLE.
- RD state:
  - Drive app_en = 1 and app_cmd = 001 until app_rdy.
  - In the cycle where app_en and app_rdy are both 1, rd_ack = 1 (combinational), and the FSM goes to IDLE next cycle.
- WR state:
  - Drive app_en = 1 and app_cmd = 000 while cmd_done = 0.
  - Drive app_wdf_wren = 1 and app_wdf_end = 1 while data_done = 0.
  - cmd_done is set on app_en & app_rdy; data_done is set on app_wdf_wren & app_wdf_rdy.
  - The two handshakes complete independently, in either order or in the same cycle.
  - wr_ack = 1 (combinational) in the cycle where both are done, counting an acceptance in that same cycle. The flags then clear and the FSM goes to IDLE.
- Client handshake: a client may drop or change its request in the cycle after its ack. Requests are only sampled again in IDLE, so a request still asserted in the ack cycle is never double-issued.
- starve_cnt:
  - Increments on each rd_ack while wr_req = 1, saturating at STARVE_LIMIT.
  - Clears on wr_ack.
- rd_outstanding:
  - Increments on rd_ack and decrements on app_rd_data_valid.
  - If both happen in the same cycle, the count is unchanged.
  - A decrement at 0 is ignored (protects against stale data after reset); the count never exceeds MAX_OUTSTANDING.
- Read data: rd_data and rd_data_valid are combinational pass-throughs and are never blocked, including in WR state.
- calib_done dropping low: an in-progress RD/WR command still completes, and no new grant is issued until it returns high.
- Reset mid-operation: any in-flight command is abandoned and all state and counters go to their reset values.

Test Plan:
- Write only: with app_rdy and app_wdf_rdy both 1, wr_req = 1, wr_addr = 0x40, wr_data = 0xA5A5 -> app_en, app_cmd = 000 and app_wdf_wren all 1 one cycle after the request; wr_ack pulses once in that same cycle.
- Split write handshake: app_rdy = 1 and app_wdf_rdy = 0 for 3 cycles, then 1 -> app_en drops after 1 cycle, app_wdf_wren is held for 4 cycles, and wr_ack pulses on the 4th cycle only.
- Simultaneous requests: wr_req and rd_req both 1 with STARVE_LIMIT = 2 -> grant order is read, read, write, and starve_cnt returns to 0 after wr_ack.
- Outstanding limit: MAX_OUTSTANDING = 8 with no read data returned -> 8 rd_acks, then no further app_en; a single app_rd_data_valid pulse allows exactly one more read.
- Read accepted and data returned in the same cycle at rd_outstanding = 3 -> rd_outstanding stays 3.
- Calibration and reset gating: calib_done = 0 with both requests high -> app_en stays 0. Asserting rst during WR with app_rdy = 0 -> all outputs return to 0, rd_outstanding = 0, and no wr_ack is produced.
